// File: rtl/ps2_msg_framer_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 message framer.
//   ps2_state_t        : framer FSM states (SEARCH, COLLECT, DONE)
//   PS2_DEF_MSG_BYTES  : default number of bytes per message
//   PS2_DEF_SYNC_BIT   : default bit index that marks a first byte
//   PS2_DEF_TIMEOUT    : default idle cycles before a partial message is dropped
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } ps2_state_t;

  localparam int PS2_DEF_MSG_BYTES = 3;
  localparam int PS2_DEF_SYNC_BIT  = 3;
  localparam int PS2_DEF_TIMEOUT   = 1024;

endpackage

// File: rtl/ps2_msg_framer_gap_timer.sv
// ---------------------------------------------------------------------------
// ps2_gap_timer
// Counts idle cycles inside a message and flags the cycle on which the gap
// has lasted TIMEOUT cycles.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   clear  : forces the count back to zero (byte accepted / not collecting)
//   tick   : one idle cycle inside a message
//   expire : combinational, high on the idle cycle that completes the gap
// ---------------------------------------------------------------------------
module ps2_gap_timer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT = PS2_DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // The count holds the number of idle cycles already seen, so the
  // TIMEOUT-th idle cycle is the one where the count equals TIMEOUT-1.
  // Clear wins over tick so an accepted byte always restarts the gap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

  assign expire = tick && (count == LAST);

endmodule

// File: rtl/ps2_msg_framer.sv
// ---------------------------------------------------------------------------
// ps2_msg_framer
// Groups a stream of received bytes into fixed-length messages. A message
// starts with a byte whose SYNC_BIT is set; the following MSG_BYTES-1 bytes
// are taken without checking. The finished message is published on
// msg_data together with a one-cycle done pulse.
//
// Build option: define PS2_FRAMER_TIMEOUT_EN to compile in the gap timeout,
// which throws away a partial message after TIMEOUT idle cycles and pulses
// drop. Without it, drop is tied low and a partial message waits forever.
//
// Ports
//   clk      : rising-edge clock
//   reset    : synchronous, active-high reset
//   in_valid : in_data carries a byte this cycle
//   in_data  : received byte
//   done     : one-cycle pulse, msg_data holds a fresh message
//   msg_data : last complete message, first byte in the top 8 bits
//   drop     : one-cycle pulse, a partial message was discarded by timeout
// ---------------------------------------------------------------------------
module ps2_msg_framer
  import ps2_pkg::*;
#(
  parameter int MSG_BYTES = PS2_DEF_MSG_BYTES,
  parameter int SYNC_BIT  = PS2_DEF_SYNC_BIT,
  parameter int TIMEOUT   = PS2_DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   done,
  output logic [8*MSG_BYTES-1:0] msg_data,
  output logic                   drop
);

  localparam int IW = $clog2(MSG_BYTES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(MSG_BYTES - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  // Reject configurations outside the supported ranges at elaboration.
  if (MSG_BYTES < 2 || MSG_BYTES > 8 || SYNC_BIT < 0 || SYNC_BIT > 7 ||
      TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
    $error("ps2_msg_framer: parameter out of range");
  end

  ps2_state_t state;
  logic [IW-1:0] idx;
  logic [7:0] byte_buf [0:MSG_BYTES-2];
  logic [8*MSG_BYTES-1:0] full_msg;
  logic sync_hit;
  logic expire;

  // A first byte is recognised in SEARCH and, so that back-to-back messages
  // lose no cycle, also in DONE.
  assign sync_hit = in_valid && in_data[SYNC_BIT];

  // The finished message is the buffered leading bytes plus the byte being
  // accepted right now, so msg_data can load on the same edge that takes the
  // last byte. Only this path ever reaches msg_data, which keeps partial
  // messages off the output.
  always_comb begin
    full_msg = '0;
    for (int i = 0; i < MSG_BYTES - 1; i++) begin
      full_msg[8*(MSG_BYTES-1-i) +: 8] = byte_buf[i];
    end
    full_msg[7:0] = in_data;
  end

  // Byte buffer for everything except the last byte. It needs no reset:
  // stale contents are always overwritten before they can be published.
  always_ff @(posedge clk) begin
    if (state != COLLECT) begin
      if (sync_hit) begin
        byte_buf[0] <= in_data;
      end
    end else if (in_valid) begin
      for (int i = 0; i < MSG_BYTES - 1; i++) begin
        if (idx == IW'(i)) begin
          byte_buf[i] <= in_data;
        end
      end
    end
  end

  // Main framing FSM. done is set on the edge that enters DONE, which makes
  // it a registered pulse that lines up exactly with the DONE state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SEARCH;
      idx      <= '0;
      done     <= 1'b0;
      msg_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        SEARCH, DONE: begin
          if (sync_hit) begin
            idx   <= ONE_IDX;
            state <= COLLECT;
          end else begin
            idx   <= '0;
            state <= SEARCH;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            if (idx == LAST_IDX) begin
              msg_data <= full_msg;
              idx      <= '0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (expire) begin
            idx   <= '0;
            state <= SEARCH;
          end
        end
        default: begin
          idx   <= '0;
          state <= SEARCH;
        end
      endcase
    end
  end

`ifdef PS2_FRAMER_TIMEOUT_EN
  logic drop_q;

  // The gap only runs while collecting; any accepted byte restarts it, and
  // leaving COLLECT holds it at zero so every new message starts fresh.
  ps2_gap_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_gap_timer (
    .clk   (clk),
    .reset (reset),
    .clear ((state != COLLECT) || in_valid),
    .tick  ((state == COLLECT) && !in_valid),
    .expire(expire)
  );

  // drop follows the expiry cycle by one edge, matching the return to SEARCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= expire;
    end
  end

  assign drop = drop_q;
`else
  assign expire = 1'b0;
  assign drop   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_msg_framer.sv
// ---------------------------------------------------------------------------
// tb_ps2_msg_framer
// Scoreboard bench for ps2_msg_framer (MSG_BYTES=3, SYNC_BIT=3, TIMEOUT=8).
// A message-level model predicts done/drop events into a queue; a monitor
// pops and compares whenever the DUT pulses done or drop.
// ---------------------------------------------------------------------------
module tb_ps2_msg_framer;

  localparam int MSG_BYTES = 3;
  localparam int SYNC_BIT  = 3;
  localparam int TIMEOUT   = 8;
`ifdef PS2_FRAMER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   done;
  logic [8*MSG_BYTES-1:0] msg_data;
  logic                   drop;

  ps2_msg_framer #(
    .MSG_BYTES(MSG_BYTES),
    .SYNC_BIT (SYNC_BIT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_data (in_data),
    .done    (done),
    .msg_data(msg_data),
    .drop    (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                     is_drop;
    logic [8*MSG_BYTES-1:0] msg;
    int                     cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  // Message-level model: whether a message is open, its bytes so far,
  // idle cycles since the last byte, and the last published message.
  bit                     m_in_msg = 1'b0;
  logic [7:0]             m_part[$];
  int                     m_idle = 0;
  logic [8*MSG_BYTES-1:0] m_last = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8*MSG_BYTES-1:0] pack_msg();
    logic [8*MSG_BYTES-1:0] r = '0;
    foreach (m_part[i]) r = (r << 8) | (8*MSG_BYTES)'(m_part[i]);
    return r;
  endfunction

  task automatic push_event(input bit is_drop, input int when);
    ev_t e;
    e.is_drop = is_drop;
    e.msg     = m_last;
    e.cyc     = when;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs (taking effect on the next rising edge) and
  // advance the model by that same edge.
  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit r);
    @(posedge clk);
    #1;
    reset    = r;
    in_valid = v;
    in_data  = d;
    if (r) begin
      m_in_msg = 1'b0;
      m_part.delete();
      m_idle   = 0;
      m_last   = '0;
    end else if (v) begin
      if (!m_in_msg) begin
        if (d[SYNC_BIT]) begin
          m_part.delete();
          m_part.push_back(d);
          m_in_msg = 1'b1;
          m_idle   = 0;
        end
      end else begin
        m_part.push_back(d);
        m_idle = 0;
        if (m_part.size() == MSG_BYTES) begin
          m_last   = pack_msg();
          m_in_msg = 1'b0;
          m_part.delete();
          push_event(1'b0, cyc + 1);
        end
      end
    end else if (m_in_msg && TO_EN) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_in_msg = 1'b0;
        m_part.delete();
        push_event(1'b1, cyc + 1);
      end
    end
  endtask

  task automatic send_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int n);
    logic [7:0] bs [3];
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    for (int i = 0; i < n; i++) applyStimulus(1'b1, bs[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  // Quiet-point check after two idle cycles: no pulse, msg_data held, and
  // no predicted event left unobserved.
  task automatic checkOutput(input string name);
    idle(2);
    @(posedge clk);
    #2;
    checks++;
    if (msg_data !== m_last || done !== 1'b0 || drop !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s: msg_data=%h done=%b drop=%b pending=%0d, required msg_data=%h done=0 drop=0 pending=0",
               name, msg_data, done, drop, exp_q.size(), m_last);
    end
  endtask

  // Monitor: every done/drop pulse must match the next predicted event in
  // kind, cycle and message; a predicted event whose cycle has passed
  // without a pulse is reported as missed.
  always @(negedge clk) begin
    ev_t ev;
    if (done === 1'b1 || drop === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_pulse: cycle %0d done=%b drop=%b msg_data=%h, required no pulse",
                 cyc, done, drop, msg_data);
      end else begin
        ev = exp_q.pop_front();
        if (done !== !ev.is_drop || drop !== ev.is_drop || cyc != ev.cyc || msg_data !== ev.msg) begin
          failures++;
          $display("[TB] FAIL event: cycle %0d done=%b drop=%b msg_data=%h, required cycle %0d done=%b drop=%b msg_data=%h",
                   cyc, done, drop, msg_data, ev.cyc, !ev.is_drop, ev.is_drop, ev.msg);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      ev = exp_q.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL missed_event: no pulse by cycle %0d, required %s at cycle %0d msg_data=%h",
               cyc, ev.is_drop ? "drop" : "done", ev.cyc, ev.msg);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    applyStimulus(1'b1, 8'hFF, 1'b1);
    applyStimulus(1'b1, 8'h08, 1'b1);
    @(posedge clk);
    #2;
    checks++;
    if (done !== 1'b0 || drop !== 1'b0 || msg_data !== '0) begin
      failures++;
      $display("[TB] FAIL reset_state: done=%b drop=%b msg_data=%h, required 0 0 000000",
               done, drop, msg_data);
    end
    idle(1);
    checkOutput("reset_idle");

    $display("[TB] basic message");
    send_bytes(8'h08, 8'h12, 8'h34, 3);
    checkOutput("basic");

    $display("[TB] discard before sync");
    send_bytes(8'h00, 8'h01, 8'h00, 2);
    send_bytes(8'h2C, 8'h55, 8'h66, 3);
    checkOutput("sync_search");

    $display("[TB] back-to-back messages");
    send_bytes(8'h08, 8'hAA, 8'hBB, 3);
    send_bytes(8'h09, 8'hCC, 8'hDD, 3);
    checkOutput("back_to_back");

`ifdef PS2_FRAMER_TIMEOUT_EN
    $display("[TB] gap timeout");
    send_bytes(8'h08, 8'h11, 8'h00, 2);
    idle(TIMEOUT);
    send_bytes(8'h22, 8'h00, 8'h00, 1);
    checkOutput("timeout_drop");
    send_bytes(8'h08, 8'h11, 8'h00, 2);
    idle(TIMEOUT - 1);
    send_bytes(8'h22, 8'h00, 8'h00, 1);
    checkOutput("timeout_edge");
`else
    $display("[TB] no timeout build");
    send_bytes(8'h08, 8'h11, 8'h00, 2);
    idle(100);
    send_bytes(8'h22, 8'h00, 8'h00, 1);
    checkOutput("no_timeout");
`endif

    $display("[TB] reset mid-message");
    send_bytes(8'h08, 8'h11, 8'h00, 2);
    applyStimulus(1'b0, 8'h00, 1'b1);
    send_bytes(8'h33, 8'h44, 8'h00, 2);
    checkOutput("reset_mid");

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = int'($urandom_range(0, 199));
      if (sel == 0) begin
        applyStimulus(1'b0, 8'($urandom), 1'b1);
      end else if (sel < 8) begin
        idle(int'($urandom_range(TIMEOUT - 3, TIMEOUT + 3)));
      end else if (sel < 140) begin
        applyStimulus(1'b1, 8'($urandom), 1'b0);
      end else begin
        applyStimulus(1'b0, 8'($urandom), 1'b0);
      end
    end
    idle(TIMEOUT + 3);
    checkOutput("random_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_msg_framer.md
PS2_MSG_FRAMER -- requirements
Module: ps2_msg_framer

Interface
REQ-001 SHALL have parameter MSG_BYTES, default 3, number of bytes per message; legal range 2..8.
REQ-002 SHALL have parameter SYNC_BIT, default 3, bit index of in_data that marks a first byte; legal range 0..7.
REQ-003 SHALL have parameter TIMEOUT, default 1024, number of idle cycles mid-message before the partial message is discarded; legal range 2..65535.
REQ-004 clk  input  1  clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  qualifies in_data; a byte is accepted on each rising edge where in_valid=1.
REQ-007 in_data  input  8  received byte.
REQ-008 done  output  1  registered one-cycle pulse: a complete message is available.
REQ-009 msg_data  output  8*MSG_BYTES  last complete message; first byte in bits [8*MSG_BYTES-1 -: 8], last byte in bits [7:0].
REQ-010 drop  output  1  registered one-cycle pulse: a partial message was discarded by timeout.

Function
REQ-011 SHALL implement the states SEARCH, COLLECT and DONE, with a byte index idx of width $clog2(MSG_BYTES+1).
REQ-012 In SEARCH, an accepted byte with in_data[SYNC_BIT]=1 SHALL be stored as byte 0, set idx=1 and go to COLLECT; other bytes SHALL be discarded.
REQ-013 In COLLECT, each accepted byte SHALL be stored at position idx and increment idx, with no sync-bit check.
REQ-014 When the byte at idx=MSG_BYTES-1 is accepted, the next state SHALL be DONE, and msg_data SHALL be updated with the full message on the same edge.
REQ-015 done SHALL be 1 exactly in the cycle the FSM is in DONE, which is one cycle after the last byte is accepted.
REQ-016 msg_data SHALL hold its value until the next entry into DONE.
REQ-017 In DONE, the incoming byte SHALL be evaluated as in SEARCH, so back-to-back messages lose no cycle.
REQ-018 In DONE with no accepted byte, the next state SHALL be SEARCH.
REQ-019 When in_valid is held high continuously, done SHALL pulse once every MSG_BYTES cycles.
REQ-020 Partial-message bytes SHALL never appear on msg_data.
REQ-021 The timeout (REQ-031) SHALL use a gap counter that is cleared on every accepted byte and on entry to COLLECT, and increments every COLLECT cycle with in_valid=0.
REQ-022 When the gap counter reaches TIMEOUT-1 and in_valid=0, the next state SHALL be SEARCH, idx SHALL clear, and drop SHALL be 1 in the following cycle.
REQ-023 If in_valid=1 on the expiry cycle, the byte SHALL be accepted and the counter cleared; no drop occurs.

Reset
REQ-024 Reset SHALL force state=SEARCH, idx=0, gap counter=0, done=0, drop=0 and msg_data=0.
REQ-025 Reset SHALL take priority over in_valid in the same cycle.
REQ-026 Reset asserted mid-message SHALL discard the partial message without a drop pulse.
REQ-027 The first byte accepted after reset deasserts SHALL be evaluated as in SEARCH.

Configuration
REQ-028 Macro PS2_FRAMER_TIMEOUT_EN SHALL control whether the gap timeout is compiled in.
REQ-029 Without PS2_FRAMER_TIMEOUT_EN, no gap counter SHALL exist, drop SHALL be tied to 0, and COLLECT SHALL wait indefinitely.
REQ-030 The port list SHALL be identical in both builds.
REQ-031 With PS2_FRAMER_TIMEOUT_EN defined, REQ-021 to REQ-023 SHALL apply.

Structure
REQ-032 Package ps2_pkg SHALL hold the state enum ps2_state_t (SEARCH, COLLECT, DONE) and the constants PS2_DEF_MSG_BYTES=3, PS2_DEF_SYNC_BIT=3 and PS2_DEF_TIMEOUT=1024.
REQ-033 Sub-module ps2_gap_timer (parameter TIMEOUT; inputs clk, reset, clear, tick; output expire) SHALL implement the gap counter, instantiated only under PS2_FRAMER_TIMEOUT_EN.

Verification
(Parameters MSG_BYTES=3, SYNC_BIT=3, TIMEOUT=8, macro defined, unless stated otherwise.)
REQ-034 Bytes 0x08, 0x12, 0x34 on consecutive cycles after reset -> done=1 in the cycle after 0x34, msg_data=0x081234, done low again next cycle.
REQ-035 Bytes 0x00, 0x01, 0x2C, 0x55, 0x66 -> first two bytes discarded; done once, msg_data=0x2C5566.
REQ-036 Continuous valid stream 0x08,0xAA,0xBB,0x09,0xCC,0xDD -> done pulses 3 cycles apart, msg_data=0x08AABB then 0x09CCDD.
REQ-037 Bytes 0x08, 0x11, then 8 idle cycles, then 0x22 -> drop=1 for one cycle, no done, 0x22 discarded in SEARCH, msg_data unchanged; repeat with 0x22 on the 8th idle cycle -> no drop, done with 0x081122.
REQ-038 Bytes 0x08, 0x11, then reset for one cycle, then 0x33, 0x44 -> no done, no drop, msg_data=0.
REQ-039 Macro undefined: bytes 0x08, 0x11, 100 idle cycles, 0x22 -> done with msg_data=0x081122, drop never asserted.
